ipxact_regbank: RTL

- Synthesisable register bank that generalises the generated register package into a clocked slave.
- Registers are parametrised in count and width, with per-register access mode (RW/RO/W1C/WO), per-register reset values and a per-register no-reset mask.
- Bus side is a single-outstanding valid/ready request/response channel; hardware side is a flattened register image plus a hardware-input bus.
- Sits between the bus adapter and the block's datapath, replacing hand-written read/write/reset functions.

---
 rtl/ipxact_regbank_pkg.sv | 40 ++++
 rtl/ipxact_regbank_cell.sv | 47 ++++
 rtl/ipxact_regbank.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ipxact_regbank_pkg.sv
// Shared types and write-merge helper for the parametrised register bank.
// The helper is also usable by verification models.
package ipxact_regbank_pkg;

  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_RO  = 2'd1,
    ACC_W1C = 2'd2,
    ACC_WO  = 2'd3
  } acc_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam int MAX_DW   = 64;
  localparam int MAX_STRB = MAX_DW / 8;

  // Operates at the widest supported width; callers zero-extend and truncate.
  function automatic logic [MAX_DW-1:0] apply_write(
    input logic [MAX_DW-1:0]   old_val,
    input logic [MAX_DW-1:0]   wdata,
    input logic [MAX_STRB-1:0] strb,
    input acc_mode_e           mode
  );
    logic [MAX_DW-1:0] mask;
    logic [MAX_DW-1:0] result;
    for (int b = 0; b < MAX_STRB; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    case (mode)
      ACC_RW, ACC_WO: result = (old_val & ~mask) | (wdata & mask);
      ACC_W1C:        result = old_val & ~(wdata & mask);
      default:        result = old_val;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ipxact_regbank_cell.sv
// One register of the bank: access-mode update rules, reset value and
// optional exemption from reset.
module ipxact_regbank_cell
  import ipxact_regbank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter acc_mode_e             MODE        = ACC_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                    NO_RESET    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [DATA_WIDTH-1:0]   hw_in,
  output logic [DATA_WIDTH-1:0]   value
);

  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] value_d;
  logic [DATA_WIDTH-1:0] wr_val;

  assign wr_val = DATA_WIDTH'(apply_write(MAX_DW'(value_q), MAX_DW'(wdata),
                                          MAX_STRB'(strb), MODE));

  // OR-ing hw_in after the clear lets a hardware set win over a W1C write.
  always_comb begin
    value_d = value_q;
    case (MODE)
      ACC_RO:  value_d = hw_in;
      ACC_W1C: value_d = (wr_en ? wr_val : value_q) | hw_in;
      default: if (wr_en) value_d = wr_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (!NO_RESET) value_q <= RESET_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/ipxact_regbank.sv
// Register bank slave: single-outstanding valid/ready request/response port
// in front of NUM_REGS access-moded registers exposed as a flat image.
//
// state   | meaning
// IDLE    | ready for a request; an accepted access is performed immediately
// RESP    | response held on rsp_* until rsp_ready
module ipxact_regbank
  import ipxact_regbank_pkg::*;
#(
  parameter int                             DATA_WIDTH    = 32,
  parameter int                             NUM_REGS      = 9,
  parameter int                             ADDR_WIDTH    = 4,
  parameter logic [2*NUM_REGS-1:0]          ACCESS        = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES  = '0,
  parameter logic [NUM_REGS-1:0]            NO_RESET_MASK = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_out,
  output logic [NUM_REGS-1:0]              wr_pulse
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0]   wr_en;
  logic [NUM_REGS-1:0]   addr_sel;
  logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
  logic [DATA_WIDTH-1:0] sel_val;
  acc_mode_e             sel_mode;
  logic                  accept;
  logic                  addr_hit;

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign addr_hit = int'(req_addr) < NUM_REGS;

  always_comb begin
    addr_sel = '0;
    sel_val  = '0;
    sel_mode = ACC_RW;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(req_addr) == i) begin
        addr_sel[i] = 1'b1;
        sel_val     = reg_val[i];
        sel_mode    = acc_mode_e'(ACCESS[2*i +: 2]);
      end
    end
  end

  // Response fields are captured at acceptance and held through RESP.
  always_comb begin
    rdata_d    = rdata_q;
    err_d      = err_q;
    wr_en      = '0;
    wr_pulse_d = '0;
    if (accept) begin
      rdata_d = '0;
      err_d   = 1'b0;
      if (!addr_hit) begin
        err_d = 1'b1;
      end else if (req_write) begin
        if (sel_mode == ACC_RO) err_d = 1'b1;
        else                    wr_en = addr_sel;
      end else if (sel_mode != ACC_WO) begin
        rdata_d = sel_val;
      end
      wr_pulse_d = wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign wr_pulse  = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    ipxact_regbank_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MODE        (acc_mode_e'(ACCESS[2*g +: 2])),
      .RESET_VALUE (RESET_VALUES[g*DATA_WIDTH +: DATA_WIDTH]),
      .NO_RESET    (NO_RESET_MASK[g])
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en[g]),
      .wdata (req_wdata),
      .strb  (req_strb),
      .hw_in (hw_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .value (reg_val[g])
    );
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = reg_val[g];
  end

endmodule
